// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: FSM states, access owner and default widths.
package dmem_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_P = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_P = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the pipeline MEM stage and a DMA/debug master,
// sequencing each access over MEM_LAT cycles with an aging counter bounding DMA starvation.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_read,
    input  logic              p_write,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic [DATA_W-1:0] p_rdata,
    output logic              p_done,
    output logic              p_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_read_en,
    output logic              m_write_en,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(MEM_LAT - 1);
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_MAX);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic              p_req, d_live, is_idle, gnt_p, gnt_d, last_cyc, p_fin, d_fin;
    logic              mem_re, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    owner_e            own;

    // d_req is still held high during its own d_ack cycle; it must not be seen as a new request.
    assign p_req    = p_read | p_write;
    assign d_live   = d_req & ~d_ack_q;
    assign is_idle  = (state_q == ARB_IDLE);
    assign own      = (d_live && (starve_q == STV_MAX || !p_req)) ? OWN_D : OWN_P;
    assign gnt_p    = is_idle & p_req  & (own == OWN_P);
    assign gnt_d    = is_idle & d_live & (own == OWN_D);
    assign last_cyc = (cnt_q == LAST);
    assign p_fin    = last_cyc & (gnt_p | (state_q == ARB_BUSY_P));
    assign d_fin    = last_cyc & (gnt_d | (state_q == ARB_BUSY_D));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ARB_IDLE: begin
                if (gnt_p || gnt_d) begin
                    mem_addr  = gnt_d ? d_addr  : p_addr;
                    mem_wdata = gnt_d ? d_wdata : p_wdata;
                    mem_we    = gnt_d ? d_we    : p_write;
                    mem_re    = !mem_we;
                    if (MEM_LAT > 1) begin
                        state_d = gnt_d ? ARB_BUSY_D : ARB_BUSY_P;
                        cnt_d   = CNT_W'(1);
                        addr_d  = mem_addr;
                        wdata_d = mem_wdata;
                        we_d    = mem_we;
                    end
                end
            end
            default: begin
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_we    = we_q;
                mem_re    = !we_q;
                if (last_cyc) begin
                    state_d = ARB_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Aging only counts cycles where DMA actually loses; its own access does not age it.
    always_comb begin
        if (d_live && !gnt_d && state_q != ARB_BUSY_D)
            starve_d = (starve_q == STV_MAX) ? starve_q : starve_q + 1'b1;
        else
            starve_d = '0;
    end

    assign d_ack_d   = d_fin;
    assign d_rdata_d = d_fin ? m_rdata : d_rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ARB_IDLE;
            cnt_q     <= '0;
            starve_q  <= '0;
            d_ack_q   <= 1'b0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            d_ack_q   <= d_ack_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        we_q    <= we_d;
    end

    // Gating with reset aborts an in-flight access in the same cycle reset asserts.
    assign m_read_en  = reset & mem_re;
    assign m_write_en = reset & mem_we;
    assign m_addr     = reset ? mem_addr  : '0;
    assign m_wdata    = reset ? mem_wdata : '0;
    assign p_done     = reset & p_fin;
    assign p_stall    = p_req & ~p_done;
    assign p_rdata    = m_rdata;
    assign d_ack      = d_ack_q;
    assign d_rdata    = d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: MEM_LAT=2 instance with a last-cycle-commit memory model,
// plus a MEM_LAT=1 instance backed by an address-derived ROM.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        p_read = 1'b0, p_write = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] p_addr = '0, p_wdata = '0, d_addr = '0, d_wdata = '0;
    logic        p_done, p_stall, d_ack, m_read_en, m_write_en;
    logic [31:0] p_rdata, d_rdata, m_addr, m_wdata, m_rdata;

    logic        p_read1 = 1'b0, p_write1 = 1'b0, d_req1 = 1'b0, d_we1 = 1'b0;
    logic [31:0] p_addr1 = '0, p_wdata1 = '0, d_addr1 = '0, d_wdata1 = '0;
    logic        p_done1, p_stall1, d_ack1, m_read_en1, m_write_en1;
    logic [31:0] p_rdata1, d_rdata1, m_addr1, m_wdata1, m_rdata1;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(4)) u_dut (
        .clk(clk), .reset(reset),
        .p_read(p_read), .p_write(p_write), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_done(p_done), .p_stall(p_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_read_en(m_read_en), .m_write_en(m_write_en), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
        .clk(clk), .reset(reset),
        .p_read(p_read1), .p_write(p_write1), .p_addr(p_addr1), .p_wdata(p_wdata1),
        .p_rdata(p_rdata1), .p_done(p_done1), .p_stall(p_stall1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_ack(d_ack1), .d_rdata(d_rdata1),
        .m_read_en(m_read_en1), .m_write_en(m_write_en1), .m_addr(m_addr1),
        .m_wdata(m_wdata1), .m_rdata(m_rdata1)
    );

    // Memory model: a write commits only when its enable has been high for LAT consecutive cycles.
    logic [31:0] mem [256];
    int          wcnt = 0;
    int          commits = 0;
    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (m_write_en) begin
            if (wcnt == LAT - 1) begin
                mem[m_addr[7:0]] <= m_wdata;
                commits <= commits + 1;
                wcnt <= 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    assign m_rdata  = mem[m_addr[7:0]];
    assign m_rdata1 = {24'hA5A5A5, m_addr1[7:0]};

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] pq[$];
    logic [31:0] dq[$];
    logic [31:0] q1[$];
    int          stall_c, we_c, done_c, first_done, ack_c, dgr, c0;
    bit          p_hold = 1'b0;
    logic [31:0] p_hold_exp = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Runs n cycles, recording events and scoreboarding load/DMA read data as it completes.
    task automatic run(input int n);
        stall_c = 0; we_c = 0; done_c = 0; first_done = 0; ack_c = 0; dgr = 0;
        for (int c = 1; c <= n; c++) begin
            bit done_s, ack_s;
            @(negedge clk);
            done_s = p_done;
            ack_s  = d_ack;
            if (p_stall) stall_c++;
            if (m_write_en) we_c++;
            if (dgr == 0 && d_req && (m_read_en || m_write_en) && m_addr == d_addr) dgr = c;
            if (done_s) begin
                done_c++;
                if (first_done == 0) first_done = c;
                if (p_read) begin
                    if (pq.size() > 0) chk("p_rdata", p_rdata, pq.pop_front());
                    else chk("p_done_unexpected", 32'(done_s), 32'h0);
                    if (p_hold) pq.push_back(p_hold_exp);
                end
            end
            if (ack_s) begin
                ack_c = c;
                if (!d_we) begin
                    if (dq.size() > 0) chk("d_rdata", d_rdata, dq.pop_front());
                    else chk("d_ack_unexpected", 32'(ack_s), 32'h0);
                end
            end
            nxt();
            if (done_s && !p_hold) begin
                p_read  = 1'b0;
                p_write = 1'b0;
            end
            if (ack_s) d_req = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state, with a pipeline request present during reset
        p_read = 1'b1;
        p_addr = 32'h10;
        @(negedge clk);
        chk("rst_m_read_en", 32'(m_read_en), 32'h0);
        chk("rst_p_done", 32'(p_done), 32'h0);
        chk("rst_p_stall", 32'(p_stall), 32'h1);
        chk("rst_m_addr", m_addr, 32'h0);
        chk("rst_d_ack", 32'(d_ack), 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_state", 32'(u_dut.state_q), 32'(ARB_IDLE));
        chk("rst_starve", 32'(u_dut.starve_q), 32'h0);
        p_read = 1'b0;
        pre_we = 1'b1; pre_addr = 8'h10; pre_data = 32'hDEADBEEF;
        nxt();
        pre_addr = 8'h30; pre_data = 32'h00001111;
        nxt();
        pre_we = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("idle_enables", 32'({m_read_en, m_write_en}), 32'h0);
        chk("idle_m_addr", m_addr, 32'h0);
        chk("idle_m_wdata", m_wdata, 32'h0);
        nxt();

        // Pipeline load, no DMA
        p_read = 1'b1; p_addr = 32'h10; pq.push_back(32'hDEADBEEF);
        run(3);
        chk("load_stalls", stall_c, 1);
        chk("load_done_cyc", first_done, 2);
        chk("load_done_cnt", done_c, 1);

        // DMA write while idle, then read it back through the pipeline
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h55;
        c0 = commits;
        run(4);
        d_we = 1'b0;
        chk("dwr_we_cycles", we_c, 2);
        chk("dwr_ack_cyc", ack_c, 3);
        chk("dwr_commits", commits - c0, 1);
        p_read = 1'b1; p_addr = 32'h20; pq.push_back(32'h55);
        run(3);
        chk("ld20_done_cyc", first_done, 2);

        // Continuous loads with d_req held: DMA forced through after 4 losing cycles
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; dq.push_back(32'hDEADBEEF);
        p_read = 1'b1; p_addr = 32'h20; p_hold = 1'b1; p_hold_exp = 32'h55;
        pq.push_back(32'h55);
        run(8);
        p_hold = 1'b0; p_read = 1'b0; pq.delete();
        chk("starve_done_cnt", done_c, 3);
        chk("starve_dma_grant", dgr, 5);
        chk("starve_ack_cyc", ack_c, 7);
        chk("starve_stalls", stall_c, 5);
        chk("starve_cleared", 32'(u_dut.starve_q), 32'h0);

        // Store arriving the cycle after a DMA grant waits, then writes exactly once
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; dq.push_back(32'hDEADBEEF);
        run(1);
        chk("st_dma_grant", dgr, 1);
        p_write = 1'b1; p_addr = 32'h40; p_wdata = 32'h77;
        c0 = commits;
        run(4);
        chk("st_ack_cyc", ack_c, 2);
        chk("st_done_cyc", first_done, 3);
        chk("st_stalls", stall_c, 2);
        chk("st_we_cycles", we_c, 2);
        chk("st_commits", commits - c0, 1);
        p_read = 1'b1; p_addr = 32'h40; pq.push_back(32'h77);
        run(3);
        chk("ld40_done_cyc", first_done, 2);

        // Reset in the middle of a DMA write
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'h99;
        c0 = commits;
        run(1);
        chk("rw_we_started", we_c, 1);
        reset = 1'b0; d_req = 1'b0; d_we = 1'b0;
        #1;
        chk("rw_we_dropped", 32'(m_write_en), 32'h0);
        run(2);
        chk("rw_no_ack", ack_c, 0);
        chk("rw_no_we", we_c, 0);
        reset = 1'b1;
        run(1);
        chk("rw_no_ack_after", ack_c, 0);
        chk("rw_state", 32'(u_dut.state_q), 32'(ARB_IDLE));
        chk("rw_starve", 32'(u_dut.starve_q), 32'h0);
        chk("rw_commits", commits - c0, 0);
        p_read = 1'b1; p_addr = 32'h30; pq.push_back(32'h00001111);
        run(3);
        chk("ld30_done_cyc", first_done, 2);

        // MEM_LAT=1: back-to-back loads complete with no stall
        for (int i = 1; i <= 4; i++) begin
            p_read1 = 1'b1; p_addr1 = i;
            q1.push_back({24'hA5A5A5, p_addr1[7:0]});
            @(negedge clk);
            chk("l1_done", 32'(p_done1), 32'h1);
            chk("l1_stall", 32'(p_stall1), 32'h0);
            if (q1.size() > 0) chk("l1_rdata", p_rdata1, q1.pop_front());
            nxt();
        end
        p_read1 = 1'b0;
        d_req1 = 1'b1; d_addr1 = 32'h7;
        @(negedge clk);
        chk("l1_dma_re", 32'(m_read_en1), 32'h1);
        nxt();
        @(negedge clk);
        chk("l1_d_ack", 32'(d_ack1), 32'h1);
        chk("l1_d_rdata", d_rdata1, 32'hA5A5A507);
        chk("l1_masked_re", 32'(m_read_en1), 32'h0);
        nxt();
        d_req1 = 1'b0;
        @(negedge clk);
        chk("l1_ack_pulse", 32'(d_ack1), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
